// File: rtl/stl_pkg.sv
// Shared helpers for the stl_lut_table slice.
//   idx_len(n) : width of an entry index for an n-entry table (at least 1 bit).
package stl_pkg;

  function automatic int idx_len(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stl_lut_match.sv
// Combinational lookup over the entry array.
//   ent_vld/ent_key/ent_data : per-entry state
//   req_key, default_out      : key to find and the miss value
//   data  : lowest-index matching entry's data, else miss value
//   hit   : at least one valid entry matched
//   multi : two or more valid entries matched
module stl_lut_match
  import stl_pkg::*;
#(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  parameter int IDX_LEN     = idx_len(NR_KEY)
) (
  input  logic [NR_KEY-1:0]               ent_vld,
  input  logic [NR_KEY-1:0][KEY_LEN-1:0]  ent_key,
  input  logic [NR_KEY-1:0][DATA_LEN-1:0] ent_data,
  input  logic [KEY_LEN-1:0]              req_key,
  input  logic [DATA_LEN-1:0]             default_out,
  output logic [DATA_LEN-1:0]             data,
  output logic                            hit,
  output logic                            multi
);

  logic [NR_KEY-1:0] match;

  for (genvar i = 0; i < NR_KEY; i++) begin : g_cmp
    assign match[i] = ent_vld[i] && (ent_key[i] == req_key);
  end

  // Walk from the top down so the lowest matching index is the last writer.
  always_comb begin
    data = (HAS_DEFAULT != 0) ? default_out : '0;
    for (int i = NR_KEY - 1; i >= 0; i--)
      if (match[i]) data = ent_data[i];
  end

  assign hit   = |match;
  assign multi = ($countones(match) > 1);

endmodule

// File: rtl/stl_lut_table.sv
// Writable lookup table with a registered valid/ready response.
//   clk, rst_n                   : clock, async active-low reset
//   wr_en/wr_idx/wr_key/wr_data  : entry write port (out-of-range idx ignored)
//   flush                        : invalidate all entries (beats a same-cycle write)
//   req_valid/req_ready/req_key  : lookup request channel, default_out sampled with it
//   rsp_valid/rsp_ready          : response channel, one-cycle latency
//   rsp_data/rsp_hit/rsp_multi   : lookup result, held while stalled
module stl_lut_table
  import stl_pkg::*;
#(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  parameter int IDX_LEN     = idx_len(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic                rsp_multi
);

  logic [NR_KEY-1:0]               ent_vld;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  ent_key;
  logic [NR_KEY-1:0][DATA_LEN-1:0] ent_data;

  logic                wr_ok, accept;
  logic [DATA_LEN-1:0] m_data;
  logic                m_hit, m_multi;

  assign wr_ok     = wr_en && (32'(wr_idx) < NR_KEY);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Valid bits are the only reset table state; flush overrides a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ent_vld <= '0;
    else if (flush) ent_vld <= '0;
    else if (wr_ok) ent_vld[wr_idx] <= 1'b1;
  end

  // Key/data are qualified by ent_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ent_key[wr_idx]  <= wr_key;
      ent_data[wr_idx] <= wr_data;
    end
  end

  stl_lut_match #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
    .HAS_DEFAULT(HAS_DEFAULT), .IDX_LEN(IDX_LEN)
  ) u_match (
    .ent_vld(ent_vld), .ent_key(ent_key), .ent_data(ent_data),
    .req_key(req_key), .default_out(default_out),
    .data(m_data), .hit(m_hit), .multi(m_multi)
  );

  // Lookup uses pre-edge table state; a held response ignores later table updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_multi <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= m_data;
      rsp_hit   <= m_hit;
      rsp_multi <= m_multi;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stl_lut_table.md
Name: stl_lut_table

Overview:
- Writable, registered successor to the combinational key/data mux: NR_KEY entries, each holding a valid bit, a key and a data word.
- Lookups use a valid/ready request channel and return data, hit and multi-hit flags one cycle later on a response channel with backpressure.
- Used for small CSR/decode/remap tables whose contents change at run time. Replaces static lut vectors with a write port and a flush.

Parameters:
- NR_KEY, 4, number of entries (>=2).
- KEY_LEN, 4, key width.
- DATA_LEN, 32, data width.
- HAS_DEFAULT, 1: on a miss, return default_out. When 0, a miss returns all-zeros.
- IDX_LEN, $clog2(NR_KEY), entry index width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_LEN  entry to write.
- wr_key  in  KEY_LEN  key written to the entry.
- wr_data  in  DATA_LEN  data written to the entry.
- flush  in  1  invalidate all entries.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  lookup request accepted this cycle.
- req_key  in  KEY_LEN  key to look up.
- default_out  in  DATA_LEN  miss value; sampled together with req_key.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_LEN  looked-up data.
- rsp_hit  out  1  at least one valid entry matched.
- rsp_multi  out  1  two or more valid entries matched.

Behaviour:
- Reset (async assert, sync release):
  - All entry valid bits = 0.
  - rsp_valid = 0; rsp_data = 0; rsp_hit = 0; rsp_multi = 0.
  - Key and data storage are not reset.
- Write port:
  - When wr_en=1 and wr_idx<NR_KEY, the entry takes key=wr_key, data=wr_data, valid=1 at the clock edge.
  - wr_idx>=NR_KEY is ignored.
- Flush: clears every valid bit at the edge. If flush and wr_en occur in the same cycle, flush wins and the written entry stays invalid.
- Match condition: entry valid && key==req_key. Invalid entries never match.
- Multi-hit: the lowest matching index supplies the data (priority, not OR-merge); rsp_multi=1.
- Miss: rsp_data = HAS_DEFAULT ? default_out : 0; rsp_hit=0; rsp_multi=0.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (combinational; no combinational path from req_valid to req_ready).
  - A request is accepted when req_valid && req_ready. Its response is registered and appears with rsp_valid=1 on the next cycle (latency 1).
  - While rsp_valid && !rsp_ready, all rsp_* outputs hold stable and req_ready=0.
  - rsp_valid drops after rsp_ready=1 unless a new request is accepted in the same cycle. That gives back-to-back throughput of 1 per cycle.
- Ordering: a lookup accepted in the same cycle as a write or flush sees the pre-edge table contents. Write and flush take effect for lookups accepted from the next cycle on.
- A held (stalled) response is not updated by later writes or flushes.
- Reset asserted mid-transaction: the pending response is dropped (rsp_valid=0 immediately) and the table is invalidated.

Decomposition:
- Shared package stl_pkg: a function computing IDX_LEN from NR_KEY.
- Sub-module stl_lut_match, purely combinational. Inputs: per-entry valid, keys and data, plus req_key and default_out. Outputs: data, hit, multi.
  - Uses a lowest-index priority select.
  - Parametrised identically to this block.
- Top level owns the storage, the write/flush logic and the response register/handshake.

Test Plan:
- Write idx0 key=3 data=0xAAAA0000; 1 cycle later lookup key=3 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0xAAAA0000, hit=1, multi=0.
- Lookup key=7 on an empty table with default_out=0xDEADBEEF, HAS_DEFAULT=1 -> rsp_data=0xDEADBEEF, hit=0. Repeat with HAS_DEFAULT=0 -> rsp_data=0.
- Write idx1 and idx3 both key=5, data 0x11 and 0x33; lookup key=5 -> rsp_data=0x11, hit=1, multi=1.
- Same-cycle write idx2 key=9 data=0x99 and lookup key=9 -> miss. Lookup key=9 on the following cycle -> hit, data 0x99.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp_* stable throughout. Then drive rsp_ready=1 and stream 4 requests -> 4 responses on 4 consecutive cycles.
- Flush together with wr_en (idx0, key=1); lookup key=1 -> miss. Then assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately, and all lookups miss after release.
